sdram_wr_feeder: RTL and testbench

- Upstream companion to the SDRAM write path. Buffers a stream of user write words in a first-word-fall-through FIFO.
- When a full burst's worth of words is buffered and the controller is not busy, it raises wr_req with an auto-incrementing burst address.
- It supplies one data word per controller new_data strobe and releases the request on wr_end.
- It sits directly in front of the controller's wr_req/wr_addr/wr_data/wr_burst_len/wr_dqm inputs.

---
 rtl/sdram_wr_feeder_if.sv | 41 ++++
 rtl/sdram_wr_feeder.sv | 160 ++++++++++++++++
 tb/tb_sdram_wr_feeder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_wr_feeder_if.sv
// Bundle of every non-clock signal between the write feeder, the user stream
// that fills it and the SDRAM controller write port that drains it.
//   slave  : the feeder's view (inputs: user stream, address load, controller
//            strobes; outputs: in_ready, write request/address/data, status)
//   master : the environment's view (user source plus controller), mirror image
interface sdram_wr_feeder_if #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 25,
   parameter int unsigned DATA_W = 16
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              addr_load;
   logic [ADDR_W-1:0] addr_load_val;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [9:0]        wr_burst_len;
   logic              wr_dqm;
   logic              new_data;
   logic              wr_end;
   logic              busy;
   logic [LVL_W-1:0]  fifo_level;
   logic [15:0]       burst_cnt;
   logic              err;

   modport slave (
      input  in_valid, in_data, addr_load, addr_load_val, new_data, wr_end, busy,
      output in_ready, wr_req, wr_addr, wr_data, wr_burst_len, wr_dqm,
             fifo_level, burst_cnt, err
   );

   modport master (
      output in_valid, in_data, addr_load, addr_load_val, new_data, wr_end, busy,
      input  in_ready, wr_req, wr_addr, wr_data, wr_burst_len, wr_dqm,
             fifo_level, burst_cnt, err
   );
endinterface

// File: rtl/sdram_wr_feeder.sv
// SDRAM write feeder: buffers user words in a first-word-fall-through FIFO and,
// once a full burst is stored and the controller is idle, requests a write
// burst at an auto-incrementing address, handing over one word per new_data.
// Ports:
//   sys_clk  : single clock, rising edge
//   sys_rst  : synchronous active-high reset
//   bus      : sdram_wr_feeder_if.slave (user stream, address load, controller
//              write port, fifo_level / burst_cnt / err status)
// DEPTH must be a power of two, at least 2 and at least BURST_LEN.
module sdram_wr_feeder #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned ADDR_W    = 25,
   parameter int unsigned DATA_W    = 16
) (
   input logic              sys_clk,
   input logic              sys_rst,
   sdram_wr_feeder_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
   localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [LVL_W-1:0]  level_after_pop;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              in_ready_q, in_ready_d;

   logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       burst_cnt_q, burst_cnt_d;
   logic              wr_req_q, wr_req_d;
   logic              err_q, err_d;

   logic              push;
   logic              pop;
   logic              start;
   logic              pop_cnt_full;

   // Handshake qualifiers; an address load in IDLE defers the start by a cycle
   assign push  = bus.in_valid && (level_q < LVL_W'(DEPTH));
   assign pop   = (state_q == S_BURST) && bus.new_data && (pop_cnt_q < CNT_W'(BURST_LEN));
   assign start = (level_q >= LVL_W'(BURST_LEN)) && !bus.busy && !bus.addr_load;
   // Burst word count including a pop happening this very cycle
   assign pop_cnt_full = ((pop_cnt_q + CNT_W'(pop)) == CNT_W'(BURST_LEN));

   // State register
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_BURST;
         S_BURST: if (bus.wr_end) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Burst control outputs: address, word count, completed-burst count, error
   always_comb begin
      wr_addr_d   = wr_addr_q;
      pop_cnt_d   = pop_cnt_q;
      burst_cnt_d = burst_cnt_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.addr_load) wr_addr_d = bus.addr_load_val;
            if (start)         pop_cnt_d = '0;
         end
         S_BURST: begin
            if (pop) pop_cnt_d = pop_cnt_q + CNT_W'(1);
            // A strobe beyond the burst length is dropped and flagged
            if (bus.new_data && !pop) err_d = 1'b1;
            if (bus.wr_end) begin
               wr_addr_d   = wr_addr_q + ADDR_W'(BURST_LEN);
               burst_cnt_d = burst_cnt_q + 16'd1;
               if (!pop_cnt_full) err_d = 1'b1;
            end
         end
         default: ;
      endcase
      wr_req_d = (state_d == S_BURST);
   end

   // FIFO pointers, level and registered head word
   always_comb begin
      wr_ptr_d        = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d        = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_after_pop = level_q - LVL_W'(pop);
      level_d         = level_after_pop + LVL_W'(push);
      in_ready_d      = (level_d < LVL_W'(DEPTH));
      wr_data_d       = wr_data_q;
      // With nothing left after the pop, the head is the word arriving now
      if (level_after_pop == '0) begin
         if (push) wr_data_d = bus.in_data;
      end else begin
         wr_data_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         wr_data_q   <= '0;
         in_ready_q  <= 1'b1;
         pop_cnt_q   <= '0;
         wr_addr_q   <= '0;
         burst_cnt_q <= '0;
         wr_req_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         wr_data_q   <= wr_data_d;
         in_ready_q  <= in_ready_d;
         pop_cnt_q   <= pop_cnt_d;
         wr_addr_q   <= wr_addr_d;
         burst_cnt_q <= burst_cnt_d;
         wr_req_q    <= wr_req_d;
         err_q       <= err_d;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge sys_clk) begin
      if (!sys_rst && push) mem_q[wr_ptr_q] <= bus.in_data;
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.wr_req       = wr_req_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.wr_burst_len = 10'(BURST_LEN);
   assign bus.wr_dqm       = 1'b0;
   assign bus.fifo_level   = level_q;
   assign bus.burst_cnt    = burst_cnt_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_sdram_wr_feeder.sv
// Directed bench for sdram_wr_feeder (DEPTH=16, BURST_LEN=8): reset, single
// burst, busy hold-off, full FIFO with concurrent push/pop, address wrap and
// protocol errors. Inputs change and outputs are sampled on the falling edge.
module tb_sdram_wr_feeder;
   logic sys_clk;
   logic sys_rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   sdram_wr_feeder_if #(.DEPTH(16), .ADDR_W(25), .DATA_W(16)) bus ();

   sdram_wr_feeder #(.DEPTH(16), .BURST_LEN(8), .ADDR_W(25), .DATA_W(16)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge sys_clk);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      repeat (3) tick();
      sys_rst = 1'b0;
   endtask

   task automatic push_words(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'(first + i);
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (bus.wr_req !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("wait_wr_req", 32'(bus.wr_req), 32'h1);
   endtask

   task automatic feed(input int n, input int first);
      for (int k = 0; k < n; k++) begin
         check("wr_data", 32'(bus.wr_data), 32'(first + k));
         bus.new_data = 1'b1;
         tick();
      end
      bus.new_data = 1'b0;
   endtask

   // wr_end pulse, then confirm the two-cycle low gap on wr_req
   task automatic end_burst();
      bus.wr_end = 1'b1;
      tick();
      bus.wr_end = 1'b0;
      check("wr_req_drop", 32'(bus.wr_req), 32'h0);
      tick();
      check("wr_req_gap", 32'(bus.wr_req), 32'h0);
   endtask

   initial begin
      int seen_req;
      sys_rst           = 1'b1;
      bus.in_valid      = 1'b1;
      bus.in_data       = 16'hAAAA;
      bus.addr_load     = 1'b0;
      bus.addr_load_val = '0;
      bus.new_data      = 1'b0;
      bus.wr_end        = 1'b0;
      bus.busy          = 1'b0;

      // Reset hold with in_valid asserted
      repeat (3) tick();
      check("rst_wr_req",    32'(bus.wr_req),       32'h0);
      check("rst_level",     32'(bus.fifo_level),   32'h0);
      check("rst_in_ready",  32'(bus.in_ready),     32'h1);
      check("rst_burst_cnt", 32'(bus.burst_cnt),    32'h0);
      check("rst_err",       32'(bus.err),          32'h0);
      check("rst_wr_addr",   32'(bus.wr_addr),      32'h0);
      check("rst_wr_data",   32'(bus.wr_data),      32'h0);
      check("burst_len",     32'(bus.wr_burst_len), 32'd8);
      check("dqm",           32'(bus.wr_dqm),       32'h0);
      bus.in_valid = 1'b0;
      sys_rst      = 1'b0;

      // Single burst, addr_load ignored while bursting
      tick();
      bus.addr_load     = 1'b1;
      bus.addr_load_val = 25'h1802001;
      tick();
      bus.addr_load = 1'b0;
      check("load_addr", 32'(bus.wr_addr), 32'h1802001);
      push_words(8, 16'h0001);
      check("s1_level8",  32'(bus.fifo_level), 32'd8);
      check("s1_no_req",  32'(bus.wr_req),     32'h0);
      check("s1_fwft",    32'(bus.wr_data),    32'h0001);
      tick();
      check("s1_req",     32'(bus.wr_req),     32'h1);
      check("s1_addr",    32'(bus.wr_addr),    32'h1802001);
      bus.addr_load     = 1'b1;
      bus.addr_load_val = 25'h0000123;
      feed(8, 16'h0001);
      bus.addr_load = 1'b0;
      check("s1_level0",  32'(bus.fifo_level), 32'd0);
      end_burst();
      check("s1_addr_inc", 32'(bus.wr_addr),   32'h1802009);
      check("s1_bcnt",     32'(bus.burst_cnt), 32'd1);
      check("s1_err",      32'(bus.err),       32'h0);

      // Busy hold-off; busy during the burst is ignored
      do_reset();
      bus.busy = 1'b1;
      push_words(8, 16'h0101);
      seen_req = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.wr_req === 1'b1) seen_req++;
         tick();
      end
      check("busy_hold", 32'(seen_req), 32'd0);
      bus.busy = 1'b0;
      tick();
      check("busy_release_req", 32'(bus.wr_req), 32'h1);
      bus.busy = 1'b1;
      feed(8, 16'h0101);
      check("busy_in_burst_req", 32'(bus.wr_req), 32'h1);
      bus.busy = 1'b0;
      end_burst();
      check("busy_bcnt", 32'(bus.burst_cnt), 32'd1);
      check("busy_addr", 32'(bus.wr_addr),   32'h8);

      // Full FIFO, then pushes offered alongside every pop
      do_reset();
      bus.busy = 1'b1;
      push_words(16, 16'h0201);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0EEE;
      repeat (2) tick();
      bus.in_valid = 1'b0;
      check("full_in_ready", 32'(bus.in_ready),   32'h0);
      check("full_level",    32'(bus.fifo_level), 32'd16);
      check("full_head",     32'(bus.wr_data),    32'h0201);
      bus.busy = 1'b0;
      tick();
      check("full_req", 32'(bus.wr_req), 32'h1);
      // First offer meets a full FIFO and is refused, so it is re-offered
      for (int k = 0; k < 8; k++) begin
         check("cc_wr_data", 32'(bus.wr_data), 32'(16'h0201 + k));
         bus.new_data = 1'b1;
         bus.in_valid = 1'b1;
         bus.in_data  = (k == 0) ? 16'h0211 : 16'(16'h0211 + k - 1);
         tick();
         check("cc_level", 32'(bus.fifo_level), 32'd15);
      end
      bus.new_data = 1'b0;
      bus.in_valid = 1'b0;
      end_burst();
      wait_req();
      check("cc_addr2", 32'(bus.wr_addr), 32'h8);
      feed(8, 16'h0209);
      check("cc_level7", 32'(bus.fifo_level), 32'd7);
      check("cc_head",   32'(bus.wr_data),    32'h0211);
      end_burst();
      check("cc_bcnt", 32'(bus.burst_cnt), 32'd2);
      check("cc_err",  32'(bus.err),       32'h0);

      // Address wrap; load and start in the same cycle defers the start
      do_reset();
      bus.busy = 1'b1;
      push_words(8, 16'h0301);
      bus.busy          = 1'b0;
      bus.addr_load     = 1'b1;
      bus.addr_load_val = 25'h1FFFFF8;
      tick();
      bus.addr_load = 1'b0;
      check("wrap_load_wins", 32'(bus.wr_req),  32'h0);
      tick();
      check("wrap_req",       32'(bus.wr_req),  32'h1);
      check("wrap_addr",      32'(bus.wr_addr), 32'h1FFFFF8);
      feed(8, 16'h0301);
      end_burst();
      check("wrap_addr0", 32'(bus.wr_addr), 32'h0);

      // Early wr_end after 5 words: leftovers lead the next burst
      do_reset();
      push_words(8, 16'h0401);
      wait_req();
      feed(5, 16'h0401);
      check("early_err_before", 32'(bus.err), 32'h0);
      end_burst();
      check("early_err",   32'(bus.err),        32'h1);
      check("early_level", 32'(bus.fifo_level), 32'd3);
      check("early_head",  32'(bus.wr_data),    32'h0406);
      check("early_bcnt",  32'(bus.burst_cnt),  32'd1);
      push_words(5, 16'h0409);
      wait_req();
      check("early_addr2", 32'(bus.wr_addr), 32'h8);
      feed(8, 16'h0406);
      end_burst();
      check("early_level0", 32'(bus.fifo_level), 32'd0);
      check("early_err_sticky", 32'(bus.err), 32'h1);

      // Ninth new_data: flagged and nothing popped
      do_reset();
      bus.busy = 1'b1;
      push_words(9, 16'h0501);
      bus.busy = 1'b0;
      wait_req();
      feed(8, 16'h0501);
      check("extra_err_before", 32'(bus.err),        32'h0);
      check("extra_level1",     32'(bus.fifo_level), 32'd1);
      bus.new_data = 1'b1;
      tick();
      bus.new_data = 1'b0;
      check("extra_err",   32'(bus.err),        32'h1);
      check("extra_level", 32'(bus.fifo_level), 32'd1);
      check("extra_head",  32'(bus.wr_data),    32'h0509);
      end_burst();
      check("extra_bcnt", 32'(bus.burst_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
